// File: rtl/ro_pair_counter.sv
// Ring-oscillator pair edge counter: counts synchronized rising edges of two RO inputs
// over a fixed window of Clk cycles and presents both counts with a Done pulse.
module ro_pair_counter #(
  parameter int SIZE   = 32,
  parameter int WINDOW = 1024,
  parameter int WIN_W  = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            RoIn1,
  input  logic            RoIn2,
  output logic [SIZE-1:0] Count1,
  output logic [SIZE-1:0] Count2,
  output logic            Busy,
  output logic            Done,
  output logic            Overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_ro1_p0, r_ro1_p1, r_ro1_p2;
  logic r_ro2_p0, r_ro2_p1, r_ro2_p2;
  logic w_strb1, w_strb2;

  logic [SIZE-1:0]  r_cnt1, r_cnt2;
  logic             r_sat1, r_sat2;
  logic [WIN_W-1:0] r_win;
  logic             w_last;

  logic [SIZE-1:0] w_cnt1_nxt, w_cnt2_nxt;
  logic            w_sat1_nxt, w_sat2_nxt;

  logic [SIZE-1:0] r_count1, r_count2;
  logic            r_overflow;

  // Saturating increment: an all-ones counter stays all-ones.
  function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
    return (&v) ? v : v + SIZE'(1);
  endfunction

  function automatic logic sat_hit(input logic [SIZE-1:0] v, input logic strb);
    return strb & (&v);
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: delayed copy for rising-edge detect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ro1_p0 <= 1'b0;
      r_ro1_p1 <= 1'b0;
      r_ro1_p2 <= 1'b0;
      r_ro2_p0 <= 1'b0;
      r_ro2_p1 <= 1'b0;
      r_ro2_p2 <= 1'b0;
    end else begin
      r_ro1_p0 <= RoIn1;
      r_ro1_p1 <= r_ro1_p0;
      r_ro1_p2 <= r_ro1_p1;
      r_ro2_p0 <= RoIn2;
      r_ro2_p1 <= r_ro2_p0;
      r_ro2_p2 <= r_ro2_p1;
    end
  end

  assign w_strb1 = r_ro1_p1 & ~r_ro1_p2;
  assign w_strb2 = r_ro2_p1 & ~r_ro2_p2;

  assign w_last     = (r_win == WIN_W'(WINDOW - 1));
  assign w_cnt1_nxt = w_strb1 ? sat_inc(r_cnt1) : r_cnt1;
  assign w_cnt2_nxt = w_strb2 ? sat_inc(r_cnt2) : r_cnt2;
  assign w_sat1_nxt = r_sat1 | sat_hit(r_cnt1, w_strb1);
  assign w_sat2_nxt = r_sat2 | sat_hit(r_cnt2, w_strb2);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_COUNT;
      S_COUNT: if (w_last) w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage window: edge counters, window counter, result registers loaded on window close
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt1     <= '0;
      r_cnt2     <= '0;
      r_sat1     <= 1'b0;
      r_sat2     <= 1'b0;
      r_win      <= '0;
      r_count1   <= '0;
      r_count2   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_cnt1 <= '0;
            r_cnt2 <= '0;
            r_sat1 <= 1'b0;
            r_sat2 <= 1'b0;
            r_win  <= '0;
          end
        end
        S_COUNT: begin
          r_win  <= r_win + WIN_W'(1);
          r_cnt1 <= w_cnt1_nxt;
          r_cnt2 <= w_cnt2_nxt;
          r_sat1 <= w_sat1_nxt;
          r_sat2 <= w_sat2_nxt;
          // Results become visible in the same cycle Done is raised.
          if (w_last) begin
            r_count1   <= w_cnt1_nxt;
            r_count2   <= w_cnt2_nxt;
            r_overflow <= w_sat1_nxt | w_sat2_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy     = (r_state == S_COUNT);
  assign Done     = (r_state == S_LATCH);
  assign Count1   = r_count1;
  assign Count2   = r_count2;
  assign Overflow = r_overflow;

endmodule
